// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single-entry output register, redirect, halt and fault handling.
// Optional transfer counter enabled by defining FETCH_PERF_EN; state output codes: 0 RUN, 1 HALT, 2 FAULT.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          AW       = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [AW-1:0] imem_a,
    input  logic [31:0]   imem_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [31:0]   out_pc,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    input  logic          halt_req,
    output logic          fault,
    output logic [31:0]   fetch_count,
    output logic [1:0]    state
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] HALT  = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    logic [31:0] pc;
    logic [31:0] fetch_addr;
    logic        fetch_due;
    logic        redir_ok;
    logic        pc_ok;

    function automatic logic in_range(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
    endfunction

    // Handshake: out_instr/out_pc are consumed when out_valid && out_ready on a rising edge;
    // while out_valid && !out_ready the output register and pc hold (redirect excepted).
    always_comb begin
        fetch_addr = redirect_valid ? redirect_pc : pc;
        imem_a     = fetch_addr[AW+1:2];
        fetch_due  = !out_valid || out_ready;
        redir_ok   = in_range(redirect_pc);
        pc_ok      = in_range(pc);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= RESET_PC;
            state     <= RUN;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            fault     <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect overrides everything, including a stalled instruction and halt.
            if (redir_ok) begin
                out_instr <= imem_rd;
                out_pc    <= redirect_pc;
                out_valid <= 1'b1;
                pc        <= redirect_pc + 32'd4;
                state     <= RUN;
                fault     <= 1'b0;
            end else begin
                out_valid <= 1'b0;
                fault     <= 1'b1;
                state     <= FAULT;
            end
        end else begin
            case (state)
                RUN: begin
                    if (fetch_due) begin
                        if (pc_ok) begin
                            out_instr <= imem_rd;
                            out_pc    <= pc;
                            out_valid <= 1'b1;
                            pc        <= pc + 32'd4;
                            if (halt_req) state <= HALT;
                        end else begin
                            out_valid <= 1'b0;
                            fault     <= 1'b1;
                            state     <= FAULT;
                        end
                    end else if (halt_req) begin
                        state <= HALT;
                    end
                end
                default: begin
                    // HALT/FAULT: no fetches, a held instruction still drains.
                    if (out_ready) out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (out_valid && out_ready) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_fetch_ctrl;

    localparam int     AW          = 6;
    localparam int     WORDS       = 1 << AW;
    localparam longint FETCH_BYTES = 4 * WORDS;
`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int M_RUN   = 0;
    localparam int M_HALT  = 1;
    localparam int M_FAULT = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] imem_a;
    logic [31:0]   imem_rd;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          halt_req;
    logic          fault;
    logic [31:0]   fetch_count;
    logic [1:0]    state;

    logic [31:0] rom [0:WORDS-1];

    // model state
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic [31:0] m_next;
    int          m_mode;
    logic [31:0] m_count;
    logic [31:0] exp_q[$];

    int errors = 0;
    int checks = 0;

    fetch_ctrl #(.RESET_PC(32'h0), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .imem_a(imem_a), .imem_rd(imem_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
        .fault(fault), .fetch_count(fetch_count), .state(state)
    );

    always #5 clk = ~clk;
    assign imem_rd = rom[imem_a];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (longint'(a) < FETCH_BYTES);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_instr = '0;
        m_pc    = '0;
        m_next  = 32'h0;
        m_mode  = M_RUN;
        m_count = '0;
        exp_q.delete();
    endtask

    task automatic compare_all();
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk("out_pc", out_pc, m_pc);
            chk("out_instr", out_instr, m_instr);
        end
        chk("fault", {31'b0, fault}, {31'b0, m_mode == M_FAULT});
        chk("state", {30'b0, state}, m_mode[31:0]);
        chk("fetch_count", fetch_count, PERF ? m_count : 32'h0);
    endtask

    // One clock: drive inputs, predict the result, clock, compare.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc, input logic hlt);
        bit          n_valid;
        logic [31:0] n_instr, n_pc, n_next;
        int          n_mode;
        bit          xfer;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = hlt;
        #1;
        chk("imem_a", {26'b0, imem_a}, ((rv ? rpc : m_next) / 4) % WORDS);
        n_valid = m_valid; n_instr = m_instr; n_pc = m_pc; n_next = m_next; n_mode = m_mode;
        xfer = m_valid && rdy;
        if (rv) begin
            if (legal(rpc)) begin
                n_valid = 1'b1; n_instr = rom[rpc / 4]; n_pc = rpc; n_next = rpc + 4; n_mode = M_RUN;
            end else begin
                n_valid = 1'b0; n_mode = M_FAULT;
            end
        end else if (m_mode == M_RUN) begin
            if (!m_valid || rdy) begin
                if (legal(m_next)) begin
                    n_valid = 1'b1; n_instr = rom[m_next / 4]; n_pc = m_next; n_next = m_next + 4;
                    n_mode = hlt ? M_HALT : M_RUN;
                end else begin
                    n_valid = 1'b0; n_mode = M_FAULT;
                end
            end else if (hlt) begin
                n_mode = M_HALT;
            end
        end else if (xfer) begin
            n_valid = 1'b0;
        end
        if (xfer) begin
            m_count = m_count + 1;
            exp_q.push_back(m_pc);
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_instr = n_instr; m_pc = n_pc; m_next = n_next; m_mode = n_mode;
        compare_all();
    endtask

    initial begin
        int          tries;
        logic [31:0] tgt;
        reset_n = 1'b0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
        for (int i = 0; i < WORDS; i++) rom[i] = $urandom;
        rom[0] = 32'h2008_0005;
        model_reset();
        #2;
        compare_all();
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // sequential fetch from reset
        step(1, 0, 0, 0);
        chk("first_valid", {31'b0, out_valid}, 32'h1);
        chk("first_instr", out_instr, 32'h2008_0005);
        chk("first_pc", out_pc, 32'h0);
        step(1, 0, 0, 0);
        chk("seq_pc4", out_pc, 32'h4);
        step(1, 0, 0, 0);
        chk("seq_pc8", out_pc, 32'h8);

        // three-cycle stall at 0x8
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("stall_pc", out_pc, 32'h8);
            chk("stall_instr", out_instr, rom[2]);
        end
        step(1, 0, 0, 0);
        chk("after_stall_pc", out_pc, 32'hC);

        // redirect while stalled at 0x10
        step(1, 0, 0, 0);
        chk("pc10", out_pc, 32'h10);
        step(0, 0, 0, 0);
        step(0, 1, 32'h40, 0);
        chk("redir_pc", out_pc, 32'h40);
        chk("redir_instr", out_instr, rom[16]);
        chk("xfer_count", m_count, 32'd4);
        chk("xfer_count_dut", fetch_count, PERF ? 32'd4 : 32'd0);
        chk("last_xfer_pc", exp_q[$], 32'hC);

        // run off the end of memory
        for (int i = 0; i < 47; i++) step(1, 0, 0, 0);
        chk("end_pc", out_pc, 32'hFC);
        step(1, 0, 0, 0);
        chk("wrap_valid", {31'b0, out_valid}, 32'h0);
        chk("wrap_fault", {31'b0, fault}, 32'h1);
        step(1, 1, 32'h0, 0);
        chk("recover_fault", {31'b0, fault}, 32'h0);
        chk("recover_pc", out_pc, 32'h0);

        // misaligned redirect, then halt+redirect together
        step(1, 1, 32'h6, 0);
        chk("misalign_fault", {31'b0, fault}, 32'h1);
        chk("misalign_valid", {31'b0, out_valid}, 32'h0);
        step(1, 1, 32'h20, 1);
        chk("halt_redir_state", {30'b0, state}, 32'h0);
        chk("halt_redir_pc", out_pc, 32'h20);

        // halt drains the held word and stops
        step(1, 0, 0, 1);
        chk("halt_pc", out_pc, 32'h24);
        chk("halt_state", {30'b0, state}, 32'h1);
        step(1, 0, 0, 0);
        chk("halt_drained", {31'b0, out_valid}, 32'h0);
        step(1, 0, 0, 0);
        step(1, 1, 32'h100, 0);
        chk("oor_fault", {31'b0, fault}, 32'h1);
        step(1, 1, 32'h80, 0);

        // reset during a stall
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk); #1;
        reset_n = 1'b1;

        // ten transfers with interleaved stalls
        tries = 0;
        while (m_count != 10 && tries < 200) begin
            step(1'($urandom_range(0, 1)), 0, 0, 0);
            tries++;
        end
        chk("count10", fetch_count, PERF ? 32'd10 : 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 60)      tgt = {24'b0, 6'($urandom_range(0, WORDS - 1)), 2'b00};
            else if (r < 80) tgt = {24'b0, 6'($urandom_range(0, WORDS - 1)), 2'($urandom_range(1, 3))};
            else             tgt = $urandom_range(256, 32'hFFFF) & 32'hFFFF_FFFC;
            step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 99) < 8), tgt,
                 1'($urandom_range(0, 99) < 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
